// File: rtl/spi_frame_scheduler_if.sv
// Bus bundle between the DSP chip-select, the encoder sampling pipeline, the
// SPI slave data inputs and the spi_frame_scheduler.
// master: the surrounding system (drives cs_n, ack, live words).
// slave : the scheduler itself.
interface spi_frame_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              cs_n;
  logic              sample_ack;
  logic [DATA_W-1:0] para_in;
  logic [DATA_W-1:0] position_in;
  logic [DATA_W-1:0] compen_in;
  logic              sample_req;
  logic [DATA_W-1:0] dsp_data_para;
  logic [DATA_W-1:0] dsp_data_position;
  logic [DATA_W-1:0] dsp_data_position_compen;
  logic              data_valid;
  logic              stale;
  logic [CNT_W-1:0]  frame_cnt;
  logic [CNT_W-1:0]  stale_cnt;
  logic [CNT_W-1:0]  abort_cnt;
  logic              wdog_err;

  modport master (
    output cs_n, sample_ack, para_in, position_in, compen_in,
    input  sample_req, dsp_data_para, dsp_data_position, dsp_data_position_compen,
    input  data_valid, stale, frame_cnt, stale_cnt, abort_cnt, wdog_err
  );

  modport slave (
    input  cs_n, sample_ack, para_in, position_in, compen_in,
    output sample_req, dsp_data_para, dsp_data_position, dsp_data_position_compen,
    output data_valid, stale, frame_cnt, stale_cnt, abort_cnt, wdog_err
  );
endinterface

// File: rtl/spi_frame_scheduler.sv
// SPI frame scheduler: on each chip-select falling edge requests one snapshot
// from the sampling pipeline, freezes it in shadow registers for the whole
// frame, and keeps frame / stale / abort bookkeeping.
// Optional HOLD watchdog enabled by defining SPI_FRAME_SCHEDULER_WDOG_EN.
module spi_frame_scheduler #(
  parameter int DATA_W      = 32,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 16,
  parameter int WDOG_CYC    = 50000
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  spi_frame_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  localparam int unsigned    TO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  state_t            r_state;
  logic              r_cs_meta, r_cs_s, r_cs_d;
  logic [2:0]        r_sync_vld;
  logic              w_fe, w_re, w_wd_trip;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_sample_req, r_data_valid, r_stale;
  logic [DATA_W-1:0] r_para, r_pos, r_comp;
  logic [CNT_W-1:0]  r_frame_cnt, r_stale_cnt, r_abort_cnt;

  // Chip-select synchroniser plus edge-detect register, preset high.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cs_meta  <= 1'b1;
      r_cs_s     <= 1'b1;
      r_cs_d     <= 1'b1;
      r_sync_vld <= '0;
    end else begin
      r_cs_meta  <= bus.cs_n;
      r_cs_s     <= r_cs_meta;
      r_cs_d     <= r_cs_s;
      r_sync_vld <= {r_sync_vld[1:0], 1'b1};
    end
  end

  // r_cs_d only counts as a real "high" once a genuine sample has reached it,
  // so a chip select already low at reset release never looks like a falling edge.
  assign w_fe = ~r_cs_s & r_cs_d & r_sync_vld[2];
  assign w_re =  r_cs_s & ~r_cs_d;

`ifdef SPI_FRAME_SCHEDULER_WDOG_EN
  localparam int unsigned     WD_W    = $clog2(WDOG_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_wdog_err;

  // A HOLD that has lasted WDOG_CYC cycles without a rising edge trips the watchdog.
  assign w_wd_trip = (r_state == S_HOLD) && !w_re && (r_wd_cnt == WD_LAST);

  // HOLD-cycle counter (zero outside HOLD) and sticky error flag.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wd_cnt   <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      if (r_state == S_HOLD) r_wd_cnt <= r_wd_cnt + WD_W'(1);
      else                   r_wd_cnt <= '0;
      if (w_wd_trip) r_wdog_err <= 1'b1;
    end
  end

  assign bus.wdog_err = r_wdog_err;
`else
  logic w_unused_wdog_cyc;
  // Keeps WDOG_CYC referenced in builds without the watchdog.
  assign w_unused_wdog_cyc = (WDOG_CYC != 0);
  assign w_wd_trip         = 1'b0;
  assign bus.wdog_err      = 1'b0;
`endif

  // Frame sequencer: request, capture or time out, then hold until cs_n rises.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= S_IDLE;
      r_sample_req <= 1'b0;
      r_data_valid <= 1'b0;
      r_stale      <= 1'b0;
      r_to_cnt     <= '0;
      r_para       <= '0;
      r_pos        <= '0;
      r_comp       <= '0;
      r_frame_cnt  <= '0;
      r_stale_cnt  <= '0;
      r_abort_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_data_valid <= 1'b0;
          if (w_fe) begin
            r_state      <= S_REQ;
            r_sample_req <= 1'b1;
            r_stale      <= 1'b0;
            r_to_cnt     <= '0;
          end
        end
        S_REQ: begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
          if (w_re) begin
            r_state      <= S_IDLE;
            r_sample_req <= 1'b0;
            if (r_abort_cnt != '1) r_abort_cnt <= r_abort_cnt + CNT_W'(1);
          end else if (bus.sample_ack) begin
            r_para       <= bus.para_in;
            r_pos        <= bus.position_in;
            r_comp       <= bus.compen_in;
            r_sample_req <= 1'b0;
            r_data_valid <= 1'b1;
            r_state      <= S_HOLD;
          end else if (r_to_cnt == TO_LAST) begin
            r_sample_req <= 1'b0;
            r_data_valid <= 1'b1;
            r_stale      <= 1'b1;
            if (r_stale_cnt != '1) r_stale_cnt <= r_stale_cnt + CNT_W'(1);
            r_state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_re) begin
            r_state      <= S_IDLE;
            r_frame_cnt  <= r_frame_cnt + CNT_W'(1);
            r_data_valid <= 1'b0;
          end else if (w_wd_trip) begin
            r_state      <= S_IDLE;
            r_data_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.sample_req               = r_sample_req;
  assign bus.data_valid               = r_data_valid;
  assign bus.stale                    = r_stale;
  assign bus.dsp_data_para            = r_para;
  assign bus.dsp_data_position        = r_pos;
  assign bus.dsp_data_position_compen = r_comp;
  assign bus.frame_cnt                = r_frame_cnt;
  assign bus.stale_cnt                = r_stale_cnt;
  assign bus.abort_cnt                = r_abort_cnt;

endmodule
